// File: rtl/four_and_exerciser_if.sv
// Purpose: bundles the exerciser's request, AND-chain stimulus/response and result signals.
// Latency: none; wiring only.
// Backpressure: none; start is a single-cycle request, ignored by the exerciser while busy.
// Optional feature macro: FOUR_AND_EXERCISER_FIRST_FAIL_EN adds first_fail_vld / first_fail_pat.
interface four_and_exerciser_if;
  logic       start;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       e_in;
  logic       f_in;
  logic       g_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
`ifdef FOUR_AND_EXERCISER_FIRST_FAIL_EN
  logic       first_fail_vld;
  logic [3:0] first_fail_pat;

  // Exerciser side: drives stimulus and results, receives start and chain responses.
  modport master (
    input  start, e_in, f_in, g_in,
    output a, b, c, d, busy, done, pass, err_cnt, first_fail_vld, first_fail_pat
  );

  // Environment side: the AND chain under test plus whoever requests runs.
  modport slave (
    output start, e_in, f_in, g_in,
    input  a, b, c, d, busy, done, pass, err_cnt, first_fail_vld, first_fail_pat
  );
`else
  // Exerciser side: drives stimulus and results, receives start and chain responses.
  modport master (
    input  start, e_in, f_in, g_in,
    output a, b, c, d, busy, done, pass, err_cnt
  );

  // Environment side: the AND chain under test plus whoever requests runs.
  modport slave (
    output start, e_in, f_in, g_in,
    input  a, b, c, d, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/four_and_exerciser.sv
// Purpose: walks all 16 patterns through an external 4-input AND chain and counts failing patterns.
// Latency: 16*(SETTLE_CYCLES+1) cycles from the first DRIVE cycle to done; all outputs registered.
// Backpressure: none; start is ignored while busy, results hold in DONE until the next start.
// Optional feature macro: FOUR_AND_EXERCISER_FIRST_FAIL_EN records the first failing pattern.
module four_and_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 1  // cycles each pattern settles before sampling, 1..15
) (
  input logic               clk,
  input logic               rst_n,
  four_and_exerciser_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] ERR_MAX     = 5'd16;

  state_t     state;
  logic [3:0] pat;
  logic [3:0] settle_cnt;
  logic [3:0] stim;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_cnt_q;

  logic [2:0] exp_resp;
  logic [2:0] got_resp;
  logic       mismatch;
  logic       err_inc;
  logic [4:0] err_next;

  // Expected chain response for the pattern currently driven, and the per-pattern error decision.
  // A multi-bit mismatch collapses to one increment; the count saturates at 16 so it can never wrap.
  always_comb begin
    exp_resp = {stim[3] & stim[2],
                stim[3] & stim[2] & stim[1],
                stim[3] & stim[2] & stim[1] & stim[0]};
    got_resp = {bus.e_in, bus.f_in, bus.g_in};
    mismatch = (got_resp != exp_resp);
    err_inc  = mismatch && (err_cnt_q != ERR_MAX);
    err_next = err_cnt_q + {4'd0, err_inc};
  end

  // Sequencer: IDLE/DONE wait for start, DRIVE holds a pattern for SETTLE_CYCLES, SAMPLE checks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pat        <= 4'd0;
      settle_cnt <= 4'd0;
      stim       <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= DRIVE;
            pat        <= 4'd0;
            settle_cnt <= 4'd0;
            stim       <= 4'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= 5'd0;
          end
        end
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        SAMPLE: begin
          err_cnt_q <= err_next;
          if (pat == 4'hF) begin
            // Last pattern: pass must include this sample's result, hence err_next.
            state  <= DONE;
            stim   <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == 5'd0);
          end else begin
            pat   <= pat + 4'd1;
            stim  <= pat + 4'd1;
            state <= DRIVE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FOUR_AND_EXERCISER_FIRST_FAIL_EN
  logic       first_fail_vld_q;
  logic [3:0] first_fail_pat_q;

  // First failing pattern of a run; sticky until the next accepted start or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld_q <= 1'b0;
      first_fail_pat_q <= 4'd0;
    end else if ((state == IDLE || state == DONE) && bus.start) begin
      first_fail_vld_q <= 1'b0;
      first_fail_pat_q <= 4'd0;
    end else if (state == SAMPLE && mismatch && !first_fail_vld_q) begin
      first_fail_vld_q <= 1'b1;
      first_fail_pat_q <= pat;
    end
  end

  assign bus.first_fail_vld = first_fail_vld_q;
  assign bus.first_fail_pat = first_fail_pat_q;
`endif

  assign bus.a       = stim[3];
  assign bus.b       = stim[2];
  assign bus.c       = stim[1];
  assign bus.d       = stim[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: doc/four_and_exerciser.md
FOUR_AND_EXERCISER -- requirements
Module: four_and_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, sets the number of cycles each pattern is driven before sampling; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to run a full exercise sequence.
REQ-005 a, b, c, d  output  1 each  stimulus to the 4-input AND chain under test.
REQ-006 e_in, f_in, g_in  input  1 each  responses from the chain under test: a&b, a&b&c, a&b&c&d.
REQ-007 busy  output  1  high while a sequence is running.
REQ-008 done  output  1  high while results are valid.
REQ-009 pass  output  1  high with done when err_cnt is 0.
REQ-010 err_cnt  output  5  count of failing patterns, 0..16.

Function
REQ-011 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-012 IDLE and DONE with start=1 SHALL go to DRIVE, set pattern counter pat[3:0]=0, and clear err_cnt, done and pass.
REQ-013 In DRIVE, {a,b,c,d} SHALL equal pat, with a=pat[3] and d=pat[0].
REQ-014 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a settle counter, and then go to SAMPLE.
REQ-015 In SAMPLE, the stimulus SHALL stay at pat, and {e_in,f_in,g_in} SHALL be compared with the expected {a&b, a&b&c, a&b&c&d}.
REQ-016 A mismatch on any of the three bits SHALL increment err_cnt by exactly 1 per pattern; a multi-bit mismatch SHALL NOT count more than once.
REQ-017 SAMPLE with pat<15 SHALL increment pat and return to DRIVE; SAMPLE with pat=15 SHALL go to DONE, so pat never wraps.
REQ-018 On entry to DONE, done SHALL be 1, pass SHALL be (err_cnt==0) including the last pattern's result, and the stimulus SHALL be 0.
REQ-019 DONE SHALL hold until start or reset.
REQ-020 busy SHALL be 1 in DRIVE and SAMPLE and 0 otherwise.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 A full run SHALL take 16*(SETTLE_CYCLES+1) cycles from the first DRIVE cycle; done SHALL rise at the edge ending the final SAMPLE.
REQ-023 err_cnt SHALL reach at most 16 and SHALL never wrap.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 While rst_n=0, all state SHALL reset asynchronously: state=IDLE, pat=0, settle counter=0, a..d=0, busy=0, done=0, pass=0, err_cnt=0.
REQ-026 Reset asserted mid-run SHALL abort the run with no partial result retained; the next start SHALL begin at pattern 0.
REQ-027 Deassertion of rst_n SHALL take effect at the next rising clk edge, and the block SHALL then stay in IDLE until start.

Configuration
REQ-028 With macro FOUR_AND_EXERCISER_FIRST_FAIL_EN defined, outputs first_fail_vld (1 bit) and first_fail_pat (4 bits) SHALL exist.
REQ-029 first_fail_pat SHALL capture pat at the first failing SAMPLE of a run, and first_fail_vld SHALL go to 1 and stay sticky.
REQ-030 Both first-fail outputs SHALL be cleared by reset and on start.
REQ-031 Without FOUR_AND_EXERCISER_FIRST_FAIL_EN, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Ideal AND-chain model, SETTLE_CYCLES=1, start pulse -> busy for 32 cycles, then done=1, pass=1, err_cnt=0.
REQ-033 g_in stuck at 0 -> err_cnt=1, pass=0; with the macro, first_fail_pat=4'hF and first_fail_vld=1.
REQ-034 e_in stuck at 1 -> err_cnt=12; with the macro, first_fail_pat=4'h0.
REQ-035 start pulsed at pattern 5 mid-run -> no restart, and final err_cnt is unchanged versus the run without the extra pulse.
REQ-036 rst_n low during pattern 7 -> all outputs 0 immediately; a later start runs pattern 0..15 cleanly with pass=1.
REQ-037 SETTLE_CYCLES=3, ideal model -> done rises 64 cycles after the first DRIVE cycle; each pattern holds for 4 cycles.
